processor: RTL and testbench
============================

// Module: processor
// PURPOSE
//  Single-cycle 32-bit MIPS-subset CPU; top of the design, no functional I/O besides clk/reset.
//  Fetches from internal instruction ROM (loaded by bench via $readmemh), executes one instruction/cycle.
//  State is observed hierarchically: imem.INSTRROM, regs.R[0:31], dmem.RAM, pc, hi, lo.
// PARAMETERS
//  IMEM_WORDS  64  depth of instruction ROM (32-bit words), instance imem, array INSTRROM[0:IMEM_WORDS-1]
//  DMEM_WORDS  64  depth of data RAM (32-bit words), instance dmem, array RAM
// PORTS
//  clk    in  1  single clock; all state updates on rising edge
//  reset  in  1  asynchronous, active-high reset
// BEHAVIOUR
//  - Reset (async, high): pc=0, hi=lo=0, R[1..31]=0; memories untouched. Fetch from 0 after release.
//  - 1 instr/cycle, no pipeline, no delay slots; PC/regs/hi/lo/dmem commit on posedge clk.
//  - Fetch: instr = INSTRROM[pc[31:2]] mod IMEM_WORDS; pc_next default pc+4.
//  - R[0] reads 0, writes ignored. Regfile: 2 comb read ports, 1 sync write port.
//  - R-type (op 0, funct): add 20, addu 21, sub 22, subu 23, and 24, or 25, slt 2A (signed),
//    sltu 2B (unsigned), jr 08 (pc=rs), mult 18 / multu 19 ({hi,lo}=64-bit product, signed/unsigned),
//    mfhi 10 / mflo 12 (rd=hi/lo). Dest rd. No overflow traps: add/sub wrap like addu/subu.
//  - I-type: addi 08 / addiu 09 (sign-ext imm), slti 0A, sltiu 0B (sign-ext imm, unsigned compare),
//    andi 0C / ori 0D (zero-ext imm), lui 0F (rt={imm,16'h0}), lw 23 / sw 2B (addr=rs+sext(imm),
//    word index addr[31:2]), beq 04 / bne 05 (taken: pc=pc+4+(sext(imm)<<2)). Dest rt.
//  - J-type: j 02 / jal 03: pc={pc_plus4[31:28],target,2'b00}; jal writes R[31]=pc+4.
//  - dmem: combinational read, synchronous write on sw. Out-of-range indices wrap modulo depth.
//  - Unknown opcode/funct: executes as NOP (pc+4, no state change).
//  - Same-cycle read/write of a register: read returns old value (new value visible next cycle).
//  - Reset asserted mid-run: pc and registers clear immediately, regardless of clk.
// STRUCTURE
//  - Shared package mips_pkg: opcode and funct localparams, ALU-control encoding.
//  - Sub-modules: instr_rom (instance imem), data_ram (dmem), reg_file (regs), alu, control
//    (main decoder + ALU decoder). hi/lo, pc and next-PC mux live in processor top.
// TESTING
//  - Constants: lui $1,0x1234; ori $1,$1,0x5678 -> R[1]=0x12345678; addi $2,$0,-1 -> R[2]=0xFFFFFFFF.
//  - sltu/bne: R[1]=0xFFFFFFFF,R[2]=1; sltu $3,$2,$1 -> R[3]=1; slt $4,$2,$1 -> R[4]=0;
//    bne $3,$0,+1 skips next instr; bne $4,$0 not taken -> pc+4.
//  - Call: jal to word 4 at pc=0 -> R[31]=4, pc=0x10; jr $31 -> pc=4.
//  - Multiply: mult 0x00010000*0x00010000 -> hi=1, lo=0; mult -2*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA;
//    multu 0xFFFFFFFF*2 -> hi=1, lo=0xFFFFFFFE; mfhi/mflo copy into rd.
//  - Fibonacci loop (addi/add/beq/j, sw results to dmem): dmem.RAM[0..9]=0,1,1,2,3,5,8,13,21,34.
//  - Reset: assert reset asynchronously mid-loop -> pc=0 and R[1..31]=0 before next edge;
//    write to $0 leaves R[0]=0; lw after sw same address returns stored word.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings and decoded-control types for the MIPS-subset core.
package mips_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef enum logic [2:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluSlt, AluSltu, AluLui
  } alu_op_e;

  typedef enum logic [1:0] {DstRt, DstRd, DstRa} dst_e;

  typedef enum logic [2:0] {WbAlu, WbMem, WbPc4, WbHi, WbLo} wb_e;

  // All-zero value of this struct is a NOP: no writes, sequential PC.
  typedef struct packed {
    logic    reg_write;
    dst_e    dst;
    wb_e     wb;
    logic    alu_imm;
    logic    imm_zext;
    alu_op_e alu_op;
    logic    mem_write;
    logic    beq;
    logic    bne;
    logic    jump;
    logic    jr;
    logic    mult;
    logic    mult_signed;
  } ctrl_t;

endpackage

// File: rtl/alu.sv
// 32-bit ALU for arithmetic, logic, compare and lui.
module alu
  import mips_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_e     op_i,
  output logic [31:0] y_o
);

  // Result select; add/sub wrap silently
  always_comb begin
    y_o = '0;
    unique case (op_i)
      AluAdd:  y_o = a_i + b_i;
      AluSub:  y_o = a_i - b_i;
      AluAnd:  y_o = a_i & b_i;
      AluOr:   y_o = a_i | b_i;
      AluSlt:  y_o = {31'h0, $signed(a_i) < $signed(b_i)};
      AluSltu: y_o = {31'h0, a_i < b_i};
      AluLui:  y_o = {b_i[15:0], 16'h0};
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/control.sv
// Main and ALU decoder: opcode/funct to control bundle. Unknown encodings decode to NOP.
module control
  import mips_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output ctrl_t      ctrl_o
);

  // Instruction decode
  always_comb begin
    ctrl_o = '0;
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          F_ADD, F_ADDU: begin
            ctrl_o.reg_write = 1'b1; ctrl_o.dst = DstRd; ctrl_o.alu_op = AluAdd;
          end
          F_SUB, F_SUBU: begin
            ctrl_o.reg_write = 1'b1; ctrl_o.dst = DstRd; ctrl_o.alu_op = AluSub;
          end
          F_AND: begin
            ctrl_o.reg_write = 1'b1; ctrl_o.dst = DstRd; ctrl_o.alu_op = AluAnd;
          end
          F_OR: begin
            ctrl_o.reg_write = 1'b1; ctrl_o.dst = DstRd; ctrl_o.alu_op = AluOr;
          end
          F_SLT: begin
            ctrl_o.reg_write = 1'b1; ctrl_o.dst = DstRd; ctrl_o.alu_op = AluSlt;
          end
          F_SLTU: begin
            ctrl_o.reg_write = 1'b1; ctrl_o.dst = DstRd; ctrl_o.alu_op = AluSltu;
          end
          F_JR:    ctrl_o.jr = 1'b1;
          F_MULT:  begin ctrl_o.mult = 1'b1; ctrl_o.mult_signed = 1'b1; end
          F_MULTU: ctrl_o.mult = 1'b1;
          F_MFHI: begin
            ctrl_o.reg_write = 1'b1; ctrl_o.dst = DstRd; ctrl_o.wb = WbHi;
          end
          F_MFLO: begin
            ctrl_o.reg_write = 1'b1; ctrl_o.dst = DstRd; ctrl_o.wb = WbLo;
          end
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl_o.reg_write = 1'b1; ctrl_o.alu_imm = 1'b1; ctrl_o.alu_op = AluAdd;
      end
      OP_SLTI: begin
        ctrl_o.reg_write = 1'b1; ctrl_o.alu_imm = 1'b1; ctrl_o.alu_op = AluSlt;
      end
      // Immediate is sign-extended, then compared unsigned
      OP_SLTIU: begin
        ctrl_o.reg_write = 1'b1; ctrl_o.alu_imm = 1'b1; ctrl_o.alu_op = AluSltu;
      end
      OP_ANDI: begin
        ctrl_o.reg_write = 1'b1; ctrl_o.alu_imm = 1'b1; ctrl_o.imm_zext = 1'b1;
        ctrl_o.alu_op = AluAnd;
      end
      OP_ORI: begin
        ctrl_o.reg_write = 1'b1; ctrl_o.alu_imm = 1'b1; ctrl_o.imm_zext = 1'b1;
        ctrl_o.alu_op = AluOr;
      end
      OP_LUI: begin
        ctrl_o.reg_write = 1'b1; ctrl_o.alu_imm = 1'b1; ctrl_o.alu_op = AluLui;
      end
      OP_LW: begin
        ctrl_o.reg_write = 1'b1; ctrl_o.alu_imm = 1'b1; ctrl_o.alu_op = AluAdd;
        ctrl_o.wb = WbMem;
      end
      OP_SW: begin
        ctrl_o.alu_imm = 1'b1; ctrl_o.alu_op = AluAdd; ctrl_o.mem_write = 1'b1;
      end
      OP_BEQ: ctrl_o.beq = 1'b1;
      OP_BNE: ctrl_o.bne = 1'b1;
      OP_J:   ctrl_o.jump = 1'b1;
      OP_JAL: begin
        ctrl_o.jump = 1'b1; ctrl_o.reg_write = 1'b1; ctrl_o.dst = DstRa; ctrl_o.wb = WbPc4;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_ram.sv
// Word-addressed data RAM: combinational read, synchronous write, no reset.
module data_ram #(
  parameter int unsigned Words = 64,
  localparam int unsigned Aw = $clog2(Words)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [Aw-1:0] addr_i,
  input  logic [31:0]   wd_i,
  output logic [31:0]   rd_o
);

  logic [31:0] RAM [0:Words-1];

  assign rd_o = RAM[addr_i];

  // Store on sw
  always_ff @(posedge clk_i) begin
    if (we_i) RAM[addr_i] <= wd_i;
  end

endmodule

// File: rtl/instr_rom.sv
// Instruction ROM; contents are preloaded externally, read combinationally.
module instr_rom #(
  parameter int unsigned Words = 64,
  localparam int unsigned Aw = $clog2(Words)
) (
  input  logic [Aw-1:0] addr_i,
  output logic [31:0]   data_o
);

  logic [31:0] INSTRROM [0:Words-1];

  assign data_o = INSTRROM[addr_i];

endmodule

// File: rtl/reg_file.sv
// 32x32 register file: two combinational read ports, one synchronous write port.
module reg_file (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);

  logic [31:0] R [0:31];

  // No write-through: a same-cycle write is only visible after the edge.
  assign rd1_o = (ra1_i == 5'd0) ? 32'h0 : R[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'h0 : R[ra2_i];

  // Async clear of all registers; writes to R[0] dropped
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) R[i] <= '0;
    end else if (we_i && (wa_i != 5'd0)) begin
      R[wa_i] <= wd_i;
    end
  end

endmodule

// File: rtl/processor.sv
// Single-cycle MIPS-subset CPU top: PC, next-PC mux, hi/lo and datapath glue.
module processor
  import mips_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 64,
  parameter int unsigned DMEM_WORDS = 64
) (
  input logic clk,
  input logic reset
);

  localparam int unsigned IAW = $clog2(IMEM_WORDS);
  localparam int unsigned DAW = $clog2(DMEM_WORDS);

  logic [31:0] pc, pc_next, pc_plus4, instr;
  logic [31:0] hi, lo;
  logic [31:0] rs_val, rt_val, imm_ext, alu_b, alu_y, mem_rd, wb_data;
  logic [4:0]  wr_addr;
  logic [63:0] product;
  logic        br_taken;
  ctrl_t       ctrl;

  instr_rom #(.Words(IMEM_WORDS)) imem (
    .addr_i (pc[IAW+1:2]),
    .data_o (instr)
  );

  control u_control (
    .op_i    (instr[31:26]),
    .funct_i (instr[5:0]),
    .ctrl_o  (ctrl)
  );

  reg_file regs (
    .clk_i (clk),
    .rst_i (reset),
    .ra1_i (instr[25:21]),
    .ra2_i (instr[20:16]),
    .we_i  (ctrl.reg_write),
    .wa_i  (wr_addr),
    .wd_i  (wb_data),
    .rd1_o (rs_val),
    .rd2_o (rt_val)
  );

  assign imm_ext = ctrl.imm_zext ? {16'h0, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
  assign alu_b   = ctrl.alu_imm ? imm_ext : rt_val;

  alu u_alu (
    .a_i  (rs_val),
    .b_i  (alu_b),
    .op_i (ctrl.alu_op),
    .y_o  (alu_y)
  );

  // Depth is a power of two, so dropping high index bits gives the modulo wrap.
  data_ram #(.Words(DMEM_WORDS)) dmem (
    .clk_i  (clk),
    .we_i   (ctrl.mem_write),
    .addr_i (alu_y[DAW+1:2]),
    .wd_i   (rt_val),
    .rd_o   (mem_rd)
  );

  assign pc_plus4 = pc + 32'd4;
  assign br_taken = (ctrl.beq && (rs_val == rt_val)) || (ctrl.bne && (rs_val != rt_val));

  // Next-PC select
  always_comb begin
    pc_next = pc_plus4;
    if (ctrl.jr)        pc_next = rs_val;
    else if (ctrl.jump) pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (br_taken)  pc_next = pc_plus4 + {imm_ext[29:0], 2'b00};
  end

  // Destination register select
  always_comb begin
    case (ctrl.dst)
      DstRd:   wr_addr = instr[15:11];
      DstRa:   wr_addr = 5'd31;
      default: wr_addr = instr[20:16];
    endcase
  end

  // Writeback source select
  always_comb begin
    case (ctrl.wb)
      WbMem:   wb_data = mem_rd;
      WbPc4:   wb_data = pc_plus4;
      WbHi:    wb_data = hi;
      WbLo:    wb_data = lo;
      default: wb_data = alu_y;
    endcase
  end

  // 64-bit product; operands widened first so the upper half is exact
  always_comb begin
    if (ctrl.mult_signed) begin
      product = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    end else begin
      product = {32'h0, rs_val} * {32'h0, rt_val};
    end
  end

  // PC register with async clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= '0;
    else       pc <= pc_next;
  end

  // hi/lo updated only by mult/multu
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (ctrl.mult) begin
      {hi, lo} <= product;
    end
  end

endmodule

// File: tb/tb_processor.sv
// Directed-program bench for the single-cycle MIPS-subset processor.
module tb_processor;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] prog [$];

  processor #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  // Load prog into ROM (rest zero = NOP) and restart from pc 0
  task automatic boot();
    reset = 1'b1;
    for (int k = 0; k < 64; k++) dut.imem.INSTRROM[k] = (k < prog.size()) ? prog[k] : 32'h0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2 reset = 1'b1;
    #2;
    checks++; if (dut.pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", dut.pc); end
    checks++; if (dut.hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", dut.hi); end
    checks++; if (dut.lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", dut.lo); end
    checks++; if (dut.regs.R[17] !== 32'h0) begin
      failures++; $display("FAIL reset_r17 got=%h exp=0", dut.regs.R[17]);
    end
  endtask

  task automatic test_constants();
    prog.delete();
    prog.push_back(enc_i(6'h0F, 0, 1, 16'h1234));       // lui  $1,0x1234
    prog.push_back(enc_i(6'h0D, 1, 1, 16'h5678));       // ori  $1,$1,0x5678
    prog.push_back(enc_i(6'h08, 0, 2, 16'hFFFF));       // addi $2,$0,-1
    prog.push_back(enc_i(6'h08, 0, 0, 16'h0005));       // addi $0,$0,5
    prog.push_back(enc_i(6'h0C, 1, 5, 16'hFFFF));       // andi $5,$1,0xffff
    prog.push_back(enc_i(6'h2B, 0, 1, 16'h0008));       // sw   $1,8($0)
    prog.push_back(enc_i(6'h23, 0, 6, 16'h0008));       // lw   $6,8($0)
    prog.push_back(enc_r(0, 2, 7, 6'h22));              // sub  $7,$0,$2
    prog.push_back(enc_r(1, 2, 8, 6'h20));              // add  $8,$1,$2
    prog.push_back(enc_i(6'h3F, 1, 9, 16'h1234));       // unknown opcode
    prog.push_back(enc_i(6'h23, 0, 10, 16'h0108));      // lw   $10,0x108($0) wraps to word 2
    prog.push_back(enc_r(1, 1, 11, 6'h3F));             // unknown funct
    boot();
    run(2);
    checks++; if (dut.regs.R[1] !== 32'h12345678) begin
      failures++; $display("FAIL lui_ori got=%h exp=12345678", dut.regs.R[1]);
    end
    run(10);
    checks++; if (dut.regs.R[2] !== 32'hFFFFFFFF) begin
      failures++; $display("FAIL addi_neg got=%h exp=ffffffff", dut.regs.R[2]);
    end
    checks++; if (dut.regs.R[0] !== 32'h0) begin
      failures++; $display("FAIL r0_write got=%h exp=0", dut.regs.R[0]);
    end
    checks++; if (dut.regs.R[5] !== 32'h00005678) begin
      failures++; $display("FAIL andi got=%h exp=00005678", dut.regs.R[5]);
    end
    checks++; if (dut.dmem.RAM[2] !== 32'h12345678) begin
      failures++; $display("FAIL sw got=%h exp=12345678", dut.dmem.RAM[2]);
    end
    checks++; if (dut.regs.R[6] !== 32'h12345678) begin
      failures++; $display("FAIL lw got=%h exp=12345678", dut.regs.R[6]);
    end
    checks++; if (dut.regs.R[7] !== 32'h00000001) begin
      failures++; $display("FAIL sub got=%h exp=00000001", dut.regs.R[7]);
    end
    checks++; if (dut.regs.R[8] !== 32'h12345677) begin
      failures++; $display("FAIL add_wrap got=%h exp=12345677", dut.regs.R[8]);
    end
    checks++; if (dut.regs.R[9] !== 32'h0) begin
      failures++; $display("FAIL unknown_op got=%h exp=0", dut.regs.R[9]);
    end
    checks++; if (dut.regs.R[10] !== 32'h12345678) begin
      failures++; $display("FAIL lw_wrap got=%h exp=12345678", dut.regs.R[10]);
    end
    checks++; if (dut.regs.R[11] !== 32'h0) begin
      failures++; $display("FAIL unknown_funct got=%h exp=0", dut.regs.R[11]);
    end
    checks++; if (dut.pc !== 32'h30) begin
      failures++; $display("FAIL const_pc got=%h exp=00000030", dut.pc);
    end
  endtask

  task automatic test_branch();
    prog.delete();
    prog.push_back(enc_i(6'h08, 0, 1, 16'hFFFF));       // 0 addi $1,$0,-1
    prog.push_back(enc_i(6'h08, 0, 2, 16'h0001));       // 1 addi $2,$0,1
    prog.push_back(enc_r(2, 1, 3, 6'h2B));              // 2 sltu $3,$2,$1
    prog.push_back(enc_r(2, 1, 4, 6'h2A));              // 3 slt  $4,$2,$1
    prog.push_back(enc_i(6'h05, 3, 0, 16'h0001));       // 4 bne  $3,$0,+1 (taken)
    prog.push_back(enc_i(6'h08, 0, 5, 16'h0055));       // 5 skipped
    prog.push_back(enc_i(6'h05, 4, 0, 16'h0001));       // 6 bne  $4,$0,+1 (not taken)
    prog.push_back(enc_i(6'h08, 0, 6, 16'h0066));       // 7 addi $6,$0,0x66
    prog.push_back(enc_i(6'h0A, 1, 7, 16'h0000));       // 8 slti $7,$1,0
    prog.push_back(enc_i(6'h0B, 2, 8, 16'hFFFF));       // 9 sltiu $8,$2,-1
    boot();
    run(5);
    checks++; if (dut.pc !== 32'h18) begin
      failures++; $display("FAIL bne_taken_pc got=%h exp=00000018", dut.pc);
    end
    run(1);
    checks++; if (dut.pc !== 32'h1C) begin
      failures++; $display("FAIL bne_not_taken_pc got=%h exp=0000001c", dut.pc);
    end
    run(3);
    checks++; if (dut.regs.R[3] !== 32'h1) begin
      failures++; $display("FAIL sltu got=%h exp=1", dut.regs.R[3]);
    end
    checks++; if (dut.regs.R[4] !== 32'h0) begin
      failures++; $display("FAIL slt got=%h exp=0", dut.regs.R[4]);
    end
    checks++; if (dut.regs.R[5] !== 32'h0) begin
      failures++; $display("FAIL branch_skip got=%h exp=0", dut.regs.R[5]);
    end
    checks++; if (dut.regs.R[6] !== 32'h66) begin
      failures++; $display("FAIL fallthrough got=%h exp=66", dut.regs.R[6]);
    end
    checks++; if (dut.regs.R[7] !== 32'h1) begin
      failures++; $display("FAIL slti got=%h exp=1", dut.regs.R[7]);
    end
    checks++; if (dut.regs.R[8] !== 32'h1) begin
      failures++; $display("FAIL sltiu got=%h exp=1", dut.regs.R[8]);
    end
  endtask

  task automatic test_call();
    prog.delete();
    prog.push_back(enc_j(6'h03, 26'd4));                // 0 jal 4
    prog.push_back(enc_i(6'h08, 0, 9, 16'h0007));       // 1 addi $9,$0,7
    prog.push_back(enc_j(6'h02, 26'd2));                // 2 j 2 (spin)
    prog.push_back(32'h0);                              // 3
    prog.push_back(enc_r(31, 0, 0, 6'h08));             // 4 jr $31
    boot();
    run(1);
    checks++; if (dut.regs.R[31] !== 32'h4) begin
      failures++; $display("FAIL jal_link got=%h exp=4", dut.regs.R[31]);
    end
    checks++; if (dut.pc !== 32'h10) begin
      failures++; $display("FAIL jal_pc got=%h exp=00000010", dut.pc);
    end
    run(1);
    checks++; if (dut.pc !== 32'h4) begin
      failures++; $display("FAIL jr_pc got=%h exp=00000004", dut.pc);
    end
    run(3);
    checks++; if (dut.regs.R[9] !== 32'h7) begin
      failures++; $display("FAIL after_return got=%h exp=7", dut.regs.R[9]);
    end
    checks++; if (dut.pc !== 32'h8) begin
      failures++; $display("FAIL j_spin_pc got=%h exp=00000008", dut.pc);
    end
  endtask

  task automatic test_mult();
    prog.delete();
    prog.push_back(enc_i(6'h0F, 0, 1, 16'h0001));       // 0 lui  $1,1
    prog.push_back(enc_r(1, 1, 0, 6'h18));              // 1 mult $1,$1
    prog.push_back(enc_i(6'h08, 0, 2, 16'hFFFE));       // 2 addi $2,$0,-2
    prog.push_back(enc_i(6'h08, 0, 3, 16'h0003));       // 3 addi $3,$0,3
    prog.push_back(enc_r(2, 3, 0, 6'h18));              // 4 mult $2,$3
    prog.push_back(enc_r(0, 0, 4, 6'h10));              // 5 mfhi $4
    prog.push_back(enc_r(0, 0, 5, 6'h12));              // 6 mflo $5
    prog.push_back(enc_i(6'h08, 0, 6, 16'hFFFF));       // 7 addi $6,$0,-1
    prog.push_back(enc_i(6'h08, 0, 7, 16'h0002));       // 8 addi $7,$0,2
    prog.push_back(enc_r(6, 7, 0, 6'h19));              // 9 multu $6,$7
    boot();
    run(2);
    checks++; if ({dut.hi, dut.lo} !== 64'h00000001_00000000) begin
      failures++; $display("FAIL mult_pow got=%h_%h exp=00000001_00000000", dut.hi, dut.lo);
    end
    run(3);
    checks++; if ({dut.hi, dut.lo} !== 64'hFFFFFFFF_FFFFFFFA) begin
      failures++; $display("FAIL mult_neg got=%h_%h exp=ffffffff_fffffffa", dut.hi, dut.lo);
    end
    run(5);
    checks++; if (dut.regs.R[4] !== 32'hFFFFFFFF) begin
      failures++; $display("FAIL mfhi got=%h exp=ffffffff", dut.regs.R[4]);
    end
    checks++; if (dut.regs.R[5] !== 32'hFFFFFFFA) begin
      failures++; $display("FAIL mflo got=%h exp=fffffffa", dut.regs.R[5]);
    end
    checks++; if ({dut.hi, dut.lo} !== 64'h00000001_FFFFFFFE) begin
      failures++; $display("FAIL multu got=%h_%h exp=00000001_fffffffe", dut.hi, dut.lo);
    end
  endtask

  task automatic load_fib();
    prog.delete();
    prog.push_back(enc_i(6'h08, 0, 1, 16'd0));          // 0 addi $1,$0,0   a
    prog.push_back(enc_i(6'h08, 0, 2, 16'd1));          // 1 addi $2,$0,1   b
    prog.push_back(enc_i(6'h08, 0, 3, 16'd0));          // 2 addi $3,$0,0   addr
    prog.push_back(enc_i(6'h08, 0, 4, 16'd40));         // 3 addi $4,$0,40  end
    prog.push_back(enc_i(6'h04, 3, 4, 16'd6));          // 4 beq  $3,$4,done
    prog.push_back(enc_i(6'h2B, 3, 1, 16'd0));          // 5 sw   $1,0($3)
    prog.push_back(enc_r(1, 2, 5, 6'h20));              // 6 add  $5,$1,$2
    prog.push_back(enc_r(0, 2, 1, 6'h20));              // 7 add  $1,$0,$2
    prog.push_back(enc_r(0, 5, 2, 6'h20));              // 8 add  $2,$0,$5
    prog.push_back(enc_i(6'h08, 3, 3, 16'd4));          // 9 addi $3,$3,4
    prog.push_back(enc_j(6'h02, 26'd4));                // 10 j 4
    prog.push_back(enc_j(6'h02, 26'd11));               // 11 done: j 11
  endtask

  task automatic test_fib();
    logic [31:0] fib [10];
    fib = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13, 32'd21, 32'd34};
    load_fib();
    boot();
    run(90);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (dut.dmem.RAM[k] !== fib[k]) begin
        failures++; $display("FAIL fib[%0d] got=%0d exp=%0d", k, dut.dmem.RAM[k], fib[k]);
      end
    end
    checks++; if (dut.pc !== 32'h2C) begin
      failures++; $display("FAIL fib_done_pc got=%h exp=0000002c", dut.pc);
    end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] any_reg;
    load_fib();
    boot();
    run(20);
    checks++; if (dut.regs.R[4] !== 32'd40) begin
      failures++; $display("FAIL pre_reset_r4 got=%h exp=00000028", dut.regs.R[4]);
    end
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checks++; if (dut.pc !== 32'h0) begin
      failures++; $display("FAIL async_reset_pc got=%h exp=0", dut.pc);
    end
    any_reg = '0;
    for (int k = 1; k < 32; k++) any_reg = any_reg | dut.regs.R[k];
    checks++; if (any_reg !== 32'h0) begin
      failures++; $display("FAIL async_reset_regs or_of_R got=%h exp=0", any_reg);
    end
    #1 reset = 1'b0;
    run(3);
    checks++; if (dut.pc !== 32'hC) begin
      failures++; $display("FAIL restart_pc got=%h exp=0000000c", dut.pc);
    end
  endtask

  initial begin
    test_reset();
    test_constants();
    test_branch();
    test_call();
    test_mult();
    test_fib();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
